// File: rtl/pipelined_ctrl_unit.sv
// Pipelined main control: ID decode, load-use stall, IF flush, and ID/EX -> EX/MEM -> MEM/WB control stages.
// Optional: define CTRL_STALL_CNT_EN to build the saturating stall counter on o_stall_cnt.
module pipelined_ctrl_unit #(
  parameter int INST_SZ     = 32,
  parameter int OPCODE_SZ   = 6,
  parameter int FUNCT_SZ    = 6,
  parameter int REG_ADDR_SZ = 5,
  parameter int ALU_OP_SZ   = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [INST_SZ-1:0]     i_instr_D,
  input  logic                   i_valid_D,
  input  logic                   i_branch_taken_D,
  output logic                   o_id_branch,
  output logic                   o_id_equal,
  output logic                   o_id_jump,
  output logic                   o_id_jump_sel,
  output logic                   o_stall,
  output logic                   o_flush_if,
  output logic                   o_illegal,
  output logic [ALU_OP_SZ+2:0]   o_ex_ctrl,
  output logic [REG_ADDR_SZ-1:0] o_ex_dst,
  output logic [1:0]             o_mem_ctrl,
  output logic [1:0]             o_wb_ctrl,
  output logic [15:0]            o_stall_cnt
);

  localparam int RS_LSB = INST_SZ - OPCODE_SZ - REG_ADDR_SZ;
  localparam int RT_LSB = RS_LSB - REG_ADDR_SZ;
  localparam int RD_LSB = RT_LSB - REG_ADDR_SZ;

  localparam logic [OPCODE_SZ-1:0] OP_RTYPE = OPCODE_SZ'(6'b000000);
  localparam logic [OPCODE_SZ-1:0] OP_LW    = OPCODE_SZ'(6'b100011);
  localparam logic [OPCODE_SZ-1:0] OP_SW    = OPCODE_SZ'(6'b101011);
  localparam logic [OPCODE_SZ-1:0] OP_ADDI  = OPCODE_SZ'(6'b001000);
  localparam logic [OPCODE_SZ-1:0] OP_BEQ   = OPCODE_SZ'(6'b000100);
  localparam logic [OPCODE_SZ-1:0] OP_BNE   = OPCODE_SZ'(6'b000101);
  localparam logic [OPCODE_SZ-1:0] OP_J     = OPCODE_SZ'(6'b000010);
  localparam logic [OPCODE_SZ-1:0] OP_JAL   = OPCODE_SZ'(6'b000011);

  localparam logic [FUNCT_SZ-1:0] FN_SLL  = FUNCT_SZ'(6'b000000);
  localparam logic [FUNCT_SZ-1:0] FN_ADDU = FUNCT_SZ'(6'b100001);
  localparam logic [FUNCT_SZ-1:0] FN_JR   = FUNCT_SZ'(6'b001000);
  localparam logic [FUNCT_SZ-1:0] FN_JALR = FUNCT_SZ'(6'b001001);

  localparam logic [ALU_OP_SZ-1:0] ALU_ADD  = ALU_OP_SZ'(2'b00);
  localparam logic [ALU_OP_SZ-1:0] ALU_SUB  = ALU_OP_SZ'(2'b01);
  localparam logic [ALU_OP_SZ-1:0] ALU_RT   = ALU_OP_SZ'(2'b10);
  localparam logic [ALU_OP_SZ-1:0] ALU_ADDI = ALU_OP_SZ'(2'b11);

  typedef struct packed {
    logic [ALU_OP_SZ-1:0] alu_op;
    logic alu_src;
    logic reg_dst;
    logic jal_sel;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
    logic branch;
    logic equal;
    logic jump;
    logic jump_sel;
    logic reads_rt;
  } dec_t;

  logic [OPCODE_SZ-1:0]   opcode;
  logic [FUNCT_SZ-1:0]    funct;
  logic [REG_ADDR_SZ-1:0] rs, rt, rd, dst;
  dec_t                   dec;
  logic                   dec_known;
  logic                   unused_instr_bits;

  assign opcode            = i_instr_D[INST_SZ-1 -: OPCODE_SZ];
  assign funct             = i_instr_D[FUNCT_SZ-1:0];
  assign rs                = i_instr_D[RS_LSB +: REG_ADDR_SZ];
  assign rt                = i_instr_D[RT_LSB +: REG_ADDR_SZ];
  assign rd                = i_instr_D[RD_LSB +: REG_ADDR_SZ];
  assign unused_instr_bits = ^i_instr_D;

  // Unknown or invalid instructions leave dec all-zero, which is the bubble encoding.
  always_comb begin
    dec       = '0;
    dec_known = 1'b0;
    if (i_valid_D) begin
      unique case (opcode)
        OP_RTYPE: begin
          if (funct == FN_JR) begin
            dec_known = 1'b1; dec.jump = 1'b1; dec.jump_sel = 1'b1;
          end else if (funct == FN_JALR) begin
            dec_known = 1'b1; dec.jump = 1'b1; dec.jump_sel = 1'b1;
            dec.jal_sel = 1'b1; dec.reg_write = 1'b1;
          end else if (funct == FN_SLL || funct == FN_ADDU) begin
            dec_known = 1'b1; dec.alu_op = ALU_RT; dec.reg_dst = 1'b1;
            dec.reg_write = 1'b1; dec.reads_rt = 1'b1;
          end
        end
        OP_LW: begin
          dec_known = 1'b1; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1;
          dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1;
        end
        OP_SW: begin
          dec_known = 1'b1; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1;
          dec.mem_write = 1'b1; dec.reads_rt = 1'b1;
        end
        OP_ADDI: begin
          dec_known = 1'b1; dec.alu_op = ALU_ADDI; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
        end
        OP_BEQ: begin
          dec_known = 1'b1; dec.alu_op = ALU_SUB; dec.branch = 1'b1;
          dec.equal = 1'b1; dec.reads_rt = 1'b1;
        end
        OP_BNE: begin
          dec_known = 1'b1; dec.alu_op = ALU_SUB; dec.branch = 1'b1; dec.reads_rt = 1'b1;
        end
        OP_J:   begin dec_known = 1'b1; dec.jump = 1'b1; end
        OP_JAL: begin
          dec_known = 1'b1; dec.jump = 1'b1; dec.jal_sel = 1'b1; dec.reg_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_id_branch   = dec.branch;
  assign o_id_equal    = dec.equal;
  assign o_id_jump     = dec.jump;
  assign o_id_jump_sel = dec.jump_sel;
  assign o_illegal     = i_valid_D & ~dec_known;

  always_comb begin
    dst = rt;
    if (dec.jal_sel)      dst = '1;
    else if (dec.reg_dst) dst = rd;
  end

  logic [ALU_OP_SZ+2:0]   ex_ctrl_q, ex_ctrl_d;
  logic [REG_ADDR_SZ-1:0] ex_dst_q, ex_dst_d;
  logic [1:0]             ex_mem_q, ex_mem_d, ex_wb_q, ex_wb_d;
  logic [1:0]             mem_ctrl_q, mem_ctrl_d, mem_wb_q, mem_wb_d;
  logic [1:0]             wb_ctrl_q, wb_ctrl_d;

  // ex_mem_q[1] is the mem_read of the instruction currently in EX.
  assign o_stall = dec_known & ex_mem_q[1] & (ex_dst_q != '0) &
                   ((ex_dst_q == rs) | (dec.reads_rt & (ex_dst_q == rt)));
  assign o_flush_if = ((dec.branch & i_branch_taken_D) | dec.jump) & ~o_stall;

  always_comb begin
    ex_ctrl_d = '0;
    ex_dst_d  = '0;
    ex_mem_d  = '0;
    ex_wb_d   = '0;
    if (dec_known && !o_stall) begin
      ex_ctrl_d = {dec.alu_op, dec.alu_src, dec.reg_dst, dec.jal_sel};
      ex_dst_d  = dst;
      ex_mem_d  = {dec.mem_read, dec.mem_write};
      ex_wb_d   = {dec.reg_write, dec.mem_to_reg};
    end
    mem_ctrl_d = ex_mem_q;
    mem_wb_d   = ex_wb_q;
    wb_ctrl_d  = mem_wb_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_ctrl_q  <= '0;
      ex_dst_q   <= '0;
      ex_mem_q   <= '0;
      ex_wb_q    <= '0;
      mem_ctrl_q <= '0;
      mem_wb_q   <= '0;
      wb_ctrl_q  <= '0;
    end else begin
      ex_ctrl_q  <= ex_ctrl_d;
      ex_dst_q   <= ex_dst_d;
      ex_mem_q   <= ex_mem_d;
      ex_wb_q    <= ex_wb_d;
      mem_ctrl_q <= mem_ctrl_d;
      mem_wb_q   <= mem_wb_d;
      wb_ctrl_q  <= wb_ctrl_d;
    end
  end

  assign o_ex_ctrl  = ex_ctrl_q;
  assign o_ex_dst   = ex_dst_q;
  assign o_mem_ctrl = mem_ctrl_q;
  assign o_wb_ctrl  = wb_ctrl_q;

`ifdef CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (o_stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign o_stall_cnt = stall_cnt_q;
`else
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipelined_ctrl_unit.sv
// Self-checking bench for pipelined_ctrl_unit: reference decode model feeding per-stage expected queues.
module tb_pipelined_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_d = '0;
  logic        valid_d = 1'b0;
  logic        taken_d = 1'b0;
  logic        id_branch, id_equal, id_jump, id_jump_sel;
  logic        stall, flush_if, illegal;
  logic [4:0]  ex_ctrl, ex_dst;
  logic [1:0]  mem_ctrl, wb_ctrl;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  pipelined_ctrl_unit dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_instr_D        (instr_d),
    .i_valid_D        (valid_d),
    .i_branch_taken_D (taken_d),
    .o_id_branch      (id_branch),
    .o_id_equal       (id_equal),
    .o_id_jump        (id_jump),
    .o_id_jump_sel    (id_jump_sel),
    .o_stall          (stall),
    .o_flush_if       (flush_if),
    .o_illegal        (illegal),
    .o_ex_ctrl        (ex_ctrl),
    .o_ex_dst         (ex_dst),
    .o_mem_ctrl       (mem_ctrl),
    .o_wb_ctrl        (wb_ctrl),
    .o_stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       known;
    logic [1:0] alu_op;
    logic alu_src, reg_dst, jal_sel, mem_read, mem_write, reg_write, mem_to_reg;
    logic branch, equal, jump, jump_sel, reads_rt;
  } exp_t;

  // Scoreboard: {ex_ctrl, ex_dst}, mem and wb fields, pushed at decode, popped after each edge.
  logic [9:0] exp_ex_q[$];
  logic [1:0] exp_mem_q[$];
  logic [1:0] exp_wb_q[$];
  logic       m_ex_memrd;
  logic [4:0] m_ex_dst;
  int         exp_stall_cnt;

  function automatic exp_t model_decode(input logic [31:0] ins, input logic v);
    exp_t d = '0;
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    if (!v) return d;
    case (op)
      6'h00: begin
        if (fn == 6'h08) begin d.known = 1; d.jump = 1; d.jump_sel = 1; end
        else if (fn == 6'h09) begin
          d.known = 1; d.jump = 1; d.jump_sel = 1; d.jal_sel = 1; d.reg_write = 1;
        end else if (fn == 6'h00 || fn == 6'h21) begin
          d.known = 1; d.alu_op = 2'b10; d.reg_dst = 1; d.reg_write = 1; d.reads_rt = 1;
        end
      end
      6'h23: begin d.known = 1; d.alu_src = 1; d.mem_read = 1; d.mem_to_reg = 1; d.reg_write = 1; end
      6'h2B: begin d.known = 1; d.alu_src = 1; d.mem_write = 1; d.reads_rt = 1; end
      6'h08: begin d.known = 1; d.alu_op = 2'b11; d.alu_src = 1; d.reg_write = 1; end
      6'h04: begin d.known = 1; d.alu_op = 2'b01; d.branch = 1; d.equal = 1; d.reads_rt = 1; end
      6'h05: begin d.known = 1; d.alu_op = 2'b01; d.branch = 1; d.reads_rt = 1; end
      6'h02: begin d.known = 1; d.jump = 1; end
      6'h03: begin d.known = 1; d.jump = 1; d.jal_sel = 1; d.reg_write = 1; end
      default: ;
    endcase
    return d;
  endfunction

  task automatic model_reset();
    exp_ex_q.delete(); exp_mem_q.delete(); exp_wb_q.delete();
    exp_mem_q.push_back(2'b00);
    exp_wb_q.push_back(2'b00);
    exp_wb_q.push_back(2'b00);
    m_ex_memrd = 1'b0;
    m_ex_dst = '0;
    exp_stall_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid_d = 1'b0; instr_d = '0; taken_d = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  // One ID cycle: drive, check combinational outputs, push expectations, clock, pop and compare.
  task automatic step(input logic [31:0] ins, input logic v, input logic tk, output logic e_stall);
    exp_t e;
    logic e_flush;
    logic [4:0] rs, rt, e_dst;
    logic [9:0] e_ex, got_ex;
    logic [1:0] e_mem, e_wb;
    @(negedge clk);
    instr_d = ins; valid_d = v; taken_d = tk;
    #1;
    e = model_decode(ins, v);
    rs = ins[25:21]; rt = ins[20:16];
    e_stall = e.known && m_ex_memrd && (m_ex_dst != 0) &&
              ((m_ex_dst == rs) || (e.reads_rt && (m_ex_dst == rt)));
    e_flush = ((e.branch && tk) || e.jump) && !e_stall;
    checks++;
    if (stall !== e_stall) begin
      errors++; $display("FAIL stall instr=%h got %b expected %b", ins, stall, e_stall);
    end
    checks++;
    if (flush_if !== e_flush) begin
      errors++; $display("FAIL flush_if instr=%h got %b expected %b", ins, flush_if, e_flush);
    end
    checks++;
    if (illegal !== (v && !e.known)) begin
      errors++; $display("FAIL illegal instr=%h got %b expected %b", ins, illegal, v && !e.known);
    end
    checks++;
    if ({id_branch, id_equal, id_jump, id_jump_sel} !== {e.branch, e.equal, e.jump, e.jump_sel}) begin
      errors++; $display("FAIL id_decode instr=%h got %b expected %b", ins,
        {id_branch, id_equal, id_jump, id_jump_sel}, {e.branch, e.equal, e.jump, e.jump_sel});
    end
    if (e_stall || !e.known) begin
      e_ex = '0; e_mem = '0; e_wb = '0;
    end else begin
      e_dst = e.jal_sel ? 5'd31 : (e.reg_dst ? ins[15:11] : rt);
      e_ex  = {e.alu_op, e.alu_src, e.reg_dst, e.jal_sel, e_dst};
      e_mem = {e.mem_read, e.mem_write};
      e_wb  = {e.reg_write, e.mem_to_reg};
    end
    if (e_stall) exp_stall_cnt++;
    exp_ex_q.push_back(e_ex);
    exp_mem_q.push_back(e_mem);
    exp_wb_q.push_back(e_wb);
    @(posedge clk);
    #1;
    got_ex = {ex_ctrl, ex_dst};
    checks++;
    if (exp_ex_q.size() == 0) begin
      errors++; $display("FAIL ex_queue_empty got %h", got_ex);
    end else begin
      e_ex = exp_ex_q.pop_front();
      if (got_ex !== e_ex) begin
        errors++; $display("FAIL ex_stage ctrl/dst got %h expected %h", got_ex, e_ex);
      end
      m_ex_memrd = e_mem[1] && !e_stall && e.known;
      m_ex_dst = e_ex[4:0];
    end
    checks++;
    if (exp_mem_q.size() == 0) begin
      errors++; $display("FAIL mem_queue_empty got %b", mem_ctrl);
    end else begin
      e_mem = exp_mem_q.pop_front();
      if (mem_ctrl !== e_mem) begin
        errors++; $display("FAIL mem_stage got %b expected %b", mem_ctrl, e_mem);
      end
    end
    checks++;
    if (exp_wb_q.size() == 0) begin
      errors++; $display("FAIL wb_queue_empty got %b", wb_ctrl);
    end else begin
      e_wb = exp_wb_q.pop_front();
      if (wb_ctrl !== e_wb) begin
        errors++; $display("FAIL wb_stage got %b expected %b", wb_ctrl, e_wb);
      end
    end
  endtask

  task automatic test_reset();
    logic s;
    do_reset();
    step(32'h8C220000, 1'b1, 1'b0, s);         // LW $2,0($1)
    @(negedge clk);
    instr_d = 32'h00432021; valid_d = 1'b1;   // ADDU $4,$2,$3 -> load-use
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL reset_pre_stall got %b expected 1", stall); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({stall, flush_if, ex_ctrl, ex_dst, mem_ctrl, wb_ctrl, stall_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_clear stall=%b flush=%b ex=%h dst=%h mem=%b wb=%b cnt=%h expected all 0",
               stall, flush_if, ex_ctrl, ex_dst, mem_ctrl, wb_ctrl, stall_cnt);
    end
    valid_d = 1'b0;
    #1;
    checks++;
    if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b expected 0", illegal); end
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    step(32'h00432021, 1'b1, 1'b0, s);
    checks++;
    if (ex_ctrl !== 5'b10010 || ex_dst !== 5'd4) begin
      errors++; $display("FAIL reset_first_decode got ctrl=%b dst=%0d expected 10010/4", ex_ctrl, ex_dst);
    end
  endtask

  task automatic test_sequence();
    logic s;
    do_reset();
    step(32'h00221821, 1'b1, 1'b0, s);         // ADDU $3,$1,$2
    checks++;
    if (ex_ctrl !== 5'b10010 || ex_dst !== 5'd3) begin
      errors++; $display("FAIL seq_addu_ex got ctrl=%b dst=%0d expected 10010/3", ex_ctrl, ex_dst);
    end
    step(32'h8C220000, 1'b1, 1'b0, s);         // LW $2,0($1)
    checks++;
    if (ex_ctrl !== 5'b00100 || mem_ctrl !== 2'b00) begin
      errors++; $display("FAIL seq_lw_ex got ctrl=%b mem=%b expected 00100/00", ex_ctrl, mem_ctrl);
    end
    step(32'hAC220000, 1'b1, 1'b0, s);         // SW reads $2 -> stalls behind LW
    checks++;
    if (mem_ctrl !== 2'b10 || wb_ctrl !== 2'b10 || ex_ctrl !== 5'b00000) begin
      errors++; $display("FAIL seq_stage got ex=%b mem=%b wb=%b expected 00000/10/10", ex_ctrl, mem_ctrl, wb_ctrl);
    end
    step(32'hAC220000, 1'b1, 1'b0, s);
    checks++;
    if (wb_ctrl !== 2'b11 || ex_ctrl !== 5'b00100) begin
      errors++; $display("FAIL seq_lw_wb got wb=%b ex=%b expected 11/00100", wb_ctrl, ex_ctrl);
    end
    repeat (3) step(32'h0, 1'b0, 1'b0, s);
  endtask

  task automatic test_load_use();
    logic s;
    do_reset();
    step(32'h8C220000, 1'b1, 1'b0, s);
    step(32'h00432021, 1'b1, 1'b0, s);         // stall cycle
    checks++;
    if (ex_ctrl !== 5'b0 || ex_dst !== 5'd0) begin
      errors++; $display("FAIL load_use_bubble got ctrl=%b dst=%0d expected 0/0", ex_ctrl, ex_dst);
    end
    step(32'h00432021, 1'b1, 1'b0, s);         // retry, no stall
    checks++;
    if (ex_ctrl !== 5'b10010 || ex_dst !== 5'd4) begin
      errors++; $display("FAIL load_use_retry got ctrl=%b dst=%0d expected 10010/4", ex_ctrl, ex_dst);
    end
    step(32'h8C200000, 1'b1, 1'b0, s);         // LW $0
    step(32'h00001821, 1'b1, 1'b0, s);         // ADDU reading $0: no stall
    step(32'h8C220000, 1'b1, 1'b0, s);         // LW $2
    step(32'h20220005, 1'b1, 1'b0, s);         // ADDI rt=$2: no stall
    repeat (3) step(32'h0, 1'b0, 1'b0, s);
  endtask

  task automatic test_flush();
    logic s;
    do_reset();
    step(32'h10220004, 1'b1, 1'b1, s);         // BEQ taken
    step(32'h10220004, 1'b1, 1'b0, s);         // BEQ not taken
    step(32'h14220004, 1'b1, 1'b1, s);         // BNE taken
    step(32'h08000010, 1'b1, 1'b0, s);         // J
    step(32'h03E00008, 1'b1, 1'b0, s);         // JR $31
    step(32'h8C220000, 1'b1, 1'b0, s);         // LW $2
    step(32'h10410004, 1'b1, 1'b1, s);         // BEQ rs=$2 taken: stalled, no flush
    step(32'h10410004, 1'b1, 1'b1, s);         // retry: flush
    repeat (3) step(32'h0, 1'b0, 1'b0, s);
  endtask

  task automatic test_jal_illegal();
    logic s;
    do_reset();
    step(32'h0C000010, 1'b1, 1'b0, s);         // JAL
    checks++;
    if (ex_dst !== 5'd31 || ex_ctrl !== 5'b00001) begin
      errors++; $display("FAIL jal_ex got ctrl=%b dst=%0d expected 00001/31", ex_ctrl, ex_dst);
    end
    step(32'h03E0F809, 1'b1, 1'b0, s);         // JALR
    step(32'hFC000000, 1'b1, 1'b0, s);         // illegal opcode
    checks++;
    if (ex_ctrl !== 5'b0 || ex_dst !== 5'd0 || wb_ctrl !== 2'b10) begin
      errors++; $display("FAIL illegal_op got ctrl=%b dst=%0d wb=%b expected 0/0/10", ex_ctrl, ex_dst, wb_ctrl);
    end
    step(32'h0000003F, 1'b1, 1'b0, s);         // illegal funct
    step(32'hFC000000, 1'b0, 1'b0, s);         // invalid slot: not illegal
    repeat (3) step(32'h0, 1'b0, 1'b0, s);
  endtask

  task automatic test_back_to_back();
    logic s;
    logic [31:0] ins;
    logic [5:0] ops[9] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h05, 6'h02, 6'h03};
    logic [5:0] fns[6] = '{6'h21, 6'h00, 6'h08, 6'h09, 6'h3F, 6'h21};
    do_reset();
    for (int i = 0; i < 150; i++) begin
      ins = {ops[$urandom_range(0, 8)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 31)), 5'd0, fns[$urandom_range(0, 5)]};
      if ($urandom_range(0, 15) == 0) ins[31:26] = 6'h3F;
      step(ins, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), s);
      if (s) step(ins, 1'b1, 1'($urandom_range(0, 1)), s);
    end
    repeat (3) step(32'h0, 1'b0, 1'b0, s);
  endtask

  task automatic test_stall_cnt();
    logic s;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(32'h8C220000, 1'b1, 1'b0, s);
      step(32'h00432021, 1'b1, 1'b0, s);
      step(32'h00432021, 1'b1, 1'b0, s);
    end
    #1;
    checks++;
`ifdef CTRL_STALL_CNT_EN
    if (stall_cnt !== 16'(exp_stall_cnt) || stall_cnt !== 16'd3) begin
      errors++; $display("FAIL stall_cnt got %0d expected %0d", stall_cnt, exp_stall_cnt);
    end
`else
    if (stall_cnt !== 16'd0) begin
      errors++; $display("FAIL stall_cnt_tied got %0d expected 0", stall_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_load_use();
    test_flush();
    test_jal_illegal();
    test_back_to_back();
    test_stall_cnt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
